data_bus_responder: RTL

Memory-side responder for the single-cycle core's data port. It answers the core's load/store requests: `addr_i` is the ALU result, `writedata_i` is the store data, and `readdata_o` feeds the core's load data input. It decodes each address to a word RAM or to a small memory-mapped peripheral set: GPIO, a free-running timer with compare, status, and interrupt enable. Reads are combinational, so the core completes a load in one cycle. Writes and all peripheral state update on the clock edge.

---
 rtl/data_bus_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/data_bus_responder.sv
// Data-port responder for the single-cycle core: word RAM plus GPIO, timer/compare,
// status and interrupt-enable registers. Reads are combinational; all state updates on clk_i.
module data_bus_responder #(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              memwrite_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       writedata_i,
  output logic [31:0]       readdata_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              irq_o
);
  localparam int unsigned AW = $clog2(RAM_WORDS);

  typedef enum logic [2:0] {
    SEL_NONE, SEL_RAM, SEL_GPIO_OUT, SEL_GPIO_IN,
    SEL_TIMER, SEL_CMP, SEL_STATUS, SEL_CTRL
  } sel_e;

  sel_e              sel;
  logic [AW-1:0]     ram_idx;
  logic              ram_we;
  logic [31:0]       ram_q [RAM_WORDS];

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_q, match_d;
  logic              badaddr_q, badaddr_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  logic              match_set, bad_set;
  logic [1:0]        status_clr;
  logic              unused_addr;

  assign unused_addr = ^addr_i[1:0];
  assign ram_idx     = addr_i[AW+1:2];

  always_comb begin
    sel = SEL_NONE;
    if (addr_i[31:AW+2] == '0) begin
      sel = SEL_RAM;
    end else begin
      case (addr_i[31:2])
        30'h400: sel = SEL_GPIO_OUT;
        30'h401: sel = SEL_GPIO_IN;
        30'h402: sel = SEL_TIMER;
        30'h403: sel = SEL_CMP;
        30'h404: sel = SEL_STATUS;
        30'h405: sel = SEL_CTRL;
        default: sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    readdata_o = '0;
    case (sel)
      SEL_RAM:      readdata_o = ram_q[ram_idx];
      SEL_GPIO_OUT: readdata_o[GPIO_W-1:0] = gpio_out_q;
      SEL_GPIO_IN:  readdata_o[GPIO_W-1:0] = sync2_q;
      SEL_TIMER:    readdata_o = timer_q;
      SEL_CMP:      readdata_o = cmp_q;
      SEL_STATUS:   readdata_o[1:0] = {badaddr_q, match_q};
      SEL_CTRL:     readdata_o[0] = irq_en_q;
      default:      readdata_o = '0;
    endcase
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    cmp_d      = cmp_q;
    irq_en_d   = irq_en_q;
    status_clr = '0;
    timer_d    = timer_q + 32'd1;
    sync1_d    = gpio_i;
    sync2_d    = sync1_q;
    if (memwrite_i) begin
      case (sel)
        SEL_GPIO_OUT: gpio_out_d = writedata_i[GPIO_W-1:0];
        SEL_TIMER:    timer_d    = writedata_i;
        SEL_CMP:      cmp_d      = writedata_i;
        SEL_STATUS:   status_clr = writedata_i[1:0];
        SEL_CTRL:     irq_en_d   = writedata_i[0];
        default:      ;
      endcase
    end
    // Match looks at the pre-write timer/compare; a new set beats a same-cycle clear.
    match_set = (timer_q == cmp_q) && (cmp_q != '0);
    bad_set   = memwrite_i && ((sel == SEL_NONE) || (sel == SEL_GPIO_IN));
    match_d   = match_set | (match_q & ~status_clr[0]);
    badaddr_d = bad_set | (badaddr_q & ~status_clr[1]);
    irq_d     = match_q & irq_en_q;
  end

  assign ram_we = memwrite_i && (sel == SEL_RAM) && reset_i;

  always_ff @(posedge clk_i) begin
    if (ram_we) ram_q[ram_idx] <= writedata_i;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      timer_q    <= '0;
      cmp_q      <= '0;
      match_q    <= 1'b0;
      badaddr_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      badaddr_q  <= badaddr_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  assign gpio_o = gpio_out_q;
  assign irq_o  = irq_q;

endmodule
